// File: rtl/vga_timing_pkg.sv
// Shared VGA raster constants and coordinate type for the timing generator and painters.
package vga_timing_pkg;

    localparam int unsigned COORD_W = 10;
    typedef logic [COORD_W-1:0] coord_t;

    // 640x480@60 horizontal timing, in pixels
    localparam int unsigned VGA_H_ACTIVE = 640;
    localparam int unsigned VGA_H_FP     = 16;
    localparam int unsigned VGA_H_SYNC   = 96;
    localparam int unsigned VGA_H_BP     = 48;

    // 640x480@60 vertical timing, in lines
    localparam int unsigned VGA_V_ACTIVE = 480;
    localparam int unsigned VGA_V_FP     = 10;
    localparam int unsigned VGA_V_SYNC   = 2;
    localparam int unsigned VGA_V_BP     = 33;

    function automatic int unsigned h_total(input int unsigned act, input int unsigned fp,
                                            input int unsigned syn, input int unsigned bp);
        return act + fp + syn + bp;
    endfunction

    function automatic int unsigned v_total(input int unsigned act, input int unsigned fp,
                                            input int unsigned syn, input int unsigned bp);
        return act + fp + syn + bp;
    endfunction

endpackage

// File: rtl/vga_pix_tick.sv
// Pixel-rate divider with a 2-flop reset-release synchroniser.
module vga_pix_tick #(
    parameter int unsigned CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    output logic pix_tick
);

    localparam int unsigned DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);

    logic [1:0]    rel_q;
    logic [DW-1:0] div_cnt;
    logic          run;

    assign run = rel_q[1];

    // Assertion is immediate; release is seen only after two clk edges.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rel_q <= 2'b00;
        else        rel_q <= {rel_q[0], 1'b1};
    end

    // Divider runs once released; tick is registered, so the first one lands CLK_DIV clocks after release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt  <= '0;
            pix_tick <= 1'b0;
        end else if (run) begin
            div_cnt  <= (div_cnt == DIV_MAX) ? '0 : div_cnt + DW'(1);
            pix_tick <= (div_cnt == DIV_MAX);
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: beam counters, sync/de decode and per-entry strobes.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE = VGA_H_ACTIVE,
    parameter int unsigned H_FP     = VGA_H_FP,
    parameter int unsigned H_SYNC   = VGA_H_SYNC,
    parameter int unsigned H_BP     = VGA_H_BP,
    parameter int unsigned V_ACTIVE = VGA_V_ACTIVE,
    parameter int unsigned V_FP     = VGA_V_FP,
    parameter int unsigned V_SYNC   = VGA_V_SYNC,
    parameter int unsigned V_BP     = VGA_V_BP,
    parameter int unsigned SYNC_POL = 0,
    parameter int unsigned CLK_DIV  = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        pix_tick,
    output coord_t      sx,
    output coord_t      sy,
    output logic        hsync,
    output logic        vsync,
    output logic        de,
    output logic        line_start,
    output logic        frame_start,
    output logic        vblank_start,
    output logic [15:0] frame_count
);

    localparam int unsigned H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int unsigned V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    if (H_TOTAL > 1024 || V_TOTAL > 1024 || H_TOTAL == 0 || V_TOTAL == 0 ||
        CLK_DIV < 1 || CLK_DIV > 16) begin : g_param_check
        $error("vga_timing_gen: totals must fit 10 bits and CLK_DIV must be 1..16");
    end

    localparam coord_t HT_M1 = coord_t'(H_TOTAL - 1);
    localparam coord_t VT_M1 = coord_t'(V_TOTAL - 1);

    // Decode thresholds are one bit wider so a window ending at 1024 still compares correctly.
    localparam logic [10:0] H_ACT_W = 11'(H_ACTIVE);
    localparam logic [10:0] HS_BEG  = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END  = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] V_ACT_W = 11'(V_ACTIVE);
    localparam logic [10:0] VS_BEG  = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_END  = 11'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic        SYNC_ON = (SYNC_POL != 0);

    vga_pix_tick #(.CLK_DIV(CLK_DIV)) u_pix_tick (
        .clk      (clk),
        .rst_n    (rst_n),
        .pix_tick (pix_tick)
    );

    coord_t      sx_nxt, sy_nxt;
    logic        frame_wrap;
    logic [10:0] sx_w, sy_w;

    assign sx_w = {1'b0, sx_nxt};
    assign sy_w = {1'b0, sy_nxt};

    // Next beam position; only a tick moves it.
    always_comb begin
        sx_nxt     = sx;
        sy_nxt     = sy;
        frame_wrap = 1'b0;
        if (pix_tick) begin
            if (sx == HT_M1) begin
                sx_nxt = '0;
                if (sy == VT_M1) begin
                    sy_nxt     = '0;
                    frame_wrap = 1'b1;
                end else begin
                    sy_nxt = sy + coord_t'(1);
                end
            end else begin
                sx_nxt = sx + coord_t'(1);
            end
        end
    end

    // Counters and decodes register together from next-state values, so they never skew.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sx           <= '0;
            sy           <= '0;
            frame_count  <= '0;
            hsync        <= ~SYNC_ON;
            vsync        <= ~SYNC_ON;
            de           <= 1'b0;
            line_start   <= 1'b0;
            frame_start  <= 1'b0;
            vblank_start <= 1'b0;
        end else begin
            sx           <= sx_nxt;
            sy           <= sy_nxt;
            if (frame_wrap) frame_count <= frame_count + 16'd1;
            hsync        <= (sx_w >= HS_BEG && sx_w < HS_END) ? SYNC_ON : ~SYNC_ON;
            vsync        <= (sy_w >= VS_BEG && sy_w < VS_END) ? SYNC_ON : ~SYNC_ON;
            de           <= (sx_w < H_ACT_W) && (sy_w < V_ACT_W);
            // Strobes mark entries only: a tick that lands on the coordinate, never the reset point.
            line_start   <= pix_tick && (sx_nxt == '0);
            frame_start  <= pix_tick && (sx_nxt == '0) && (sy_nxt == '0);
            vblank_start <= pix_tick && (sx_nxt == '0) && (sy_w == V_ACT_W);
        end
    end

endmodule
